// File: rtl/gowin_ddr_pkg.sv
// ============================================================
// Package : gowin_ddr_pkg
// Desc    : shared types and constants for read-phase calibration
// Rev     : 1.0
// ============================================================
`default_nettype none

package gowin_ddr_pkg;

    localparam int NUM_PHASES = 8;
    localparam int PHASE_W    = 3;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_WAIT_LOCK   = 4'd1,
        ST_SETTLE      = 4'd2,
        ST_TEST        = 4'd3,
        ST_STEP_HI     = 4'd4,
        ST_STEP_LO     = 4'd5,
        ST_ANALYSE     = 4'd6,
        ST_MOVE_HI     = 4'd7,
        ST_MOVE_LO     = 4'd8,
        ST_MOVE_SETTLE = 4'd9,
        ST_DONE        = 4'd10,
        ST_FAIL        = 4'd11
    } cal_state_t;

endpackage

`default_nettype wire

// File: rtl/gowin_ddr_phase_window_find.sv
// ============================================================
// Module : gowin_ddr_phase_window_find
// Desc   : longest circular run of passing phases and its centre
// Rev    : 1.0
// ============================================================
`default_nettype none

module gowin_ddr_phase_window_find
    import gowin_ddr_pkg::*;
#(
    parameter int MIN_WINDOW = 2
) (
    input  logic [NUM_PHASES-1:0] pass_map,
    output logic [PHASE_W-1:0]    best_phase,
    output logic [3:0]            win_len,
    output logic                  win_ok
);

    logic [3:0] w_run;
    logic       w_open;

    always_comb begin
        best_phase = '0;
        win_len    = '0;
        w_run      = '0;
        w_open     = 1'b0;
        if (&pass_map) begin
            win_len = 4'd8;
        end else begin
            // Ascending scan with strict compare keeps the lowest start on ties
            for (int s = 0; s < NUM_PHASES; s++) begin
                if (pass_map[3'(s)] && !pass_map[3'(s + 7)]) begin
                    w_run  = '0;
                    w_open = 1'b1;
                    for (int k = 0; k < NUM_PHASES - 1; k++) begin
                        if (w_open && pass_map[3'(s + k)])
                            w_run = w_run + 4'd1;
                        else
                            w_open = 1'b0;
                    end
                    if (w_run > win_len) begin
                        win_len    = w_run;
                        best_phase = 3'(s) + 3'((w_run - 4'd1) >> 1);
                    end
                end
            end
        end
        win_ok = (win_len >= 4'(MIN_WINDOW));
    end

endmodule

`default_nettype wire

// File: rtl/gowin_ddr_read_phase_cal.sv
// ============================================================
// Module : gowin_ddr_read_phase_cal
// Desc   : sweeps PLL read phase, tests each position, centres in pass window
// Rev    : 1.0
// ============================================================
`default_nettype none

module gowin_ddr_read_phase_cal
    import gowin_ddr_pkg::*;
#(
    parameter int STEP_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 64,
    parameter int TEST_TIMEOUT  = 1024,
    parameter int MIN_WINDOW    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  cal_start,
    output logic                  test_req,
    input  logic                  test_ack,
    input  logic                  test_pass,
    output logic                  phase_step,
    output logic                  phase_updn,
    output logic [PHASE_W-1:0]    cur_phase,
    output logic [NUM_PHASES-1:0] pass_map,
    output logic [PHASE_W-1:0]    best_phase,
    output logic                  cal_busy,
    output logic                  cal_done,
    output logic                  cal_fail
);

    localparam int CNT_MAX_A = (TEST_TIMEOUT > SETTLE_CYCLES) ? TEST_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > STEP_CYCLES) ? CNT_MAX_A : STEP_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] c_step_last    = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_settle_last  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TEST_TIMEOUT - 1);

    cal_state_t          r_state;
    logic                r_lock_meta;
    logic                r_lock_sync;
    logic                r_start_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_sweep;
    logic [PHASE_W-1:0]  r_move_left;

    logic [PHASE_W-1:0]  w_best;
    logic [3:0]          w_win_len;
    logic                w_win_ok;
    logic [PHASE_W-1:0]  w_delta;
    logic                w_accept;
    logic                w_start_rise;
    logic                w_lock_lost;

    gowin_ddr_phase_window_find #(
        .MIN_WINDOW (MIN_WINDOW)
    ) u_window_find (
        .pass_map   (pass_map),
        .best_phase (w_best),
        .win_len    (w_win_len),
        .win_ok     (w_win_ok)
    );

    // A zero-length window is never accepted, even if MIN_WINDOW is set to 0
    assign w_accept     = w_win_ok && (w_win_len != 4'd0);
    assign w_delta      = w_best - cur_phase;
    assign w_start_rise = cal_start && !r_start_d;
    assign cal_busy     = !(r_state inside {ST_IDLE, ST_DONE, ST_FAIL});
    assign w_lock_lost  = cal_busy && (r_state != ST_WAIT_LOCK) && !r_lock_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_start_d   <= 1'b0;
            r_cnt       <= '0;
            r_sweep     <= '0;
            r_move_left <= '0;
            test_req    <= 1'b0;
            phase_step  <= 1'b0;
            phase_updn  <= 1'b0;
            cur_phase   <= '0;
            pass_map    <= '0;
            best_phase  <= '0;
            cal_done    <= 1'b0;
            cal_fail    <= 1'b0;
        end else begin
            r_lock_meta <= locked;
            r_lock_sync <= r_lock_meta;
            r_start_d   <= cal_start;
            r_cnt       <= r_cnt + 1'b1;

            if (w_lock_lost) begin
                r_state    <= ST_FAIL;
                cal_fail   <= 1'b1;
                phase_step <= 1'b0;
                test_req   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE, ST_FAIL: begin
                        if (w_start_rise) begin
                            pass_map <= '0;
                            r_sweep  <= '0;
                            cal_done <= 1'b0;
                            cal_fail <= 1'b0;
                            r_state  <= ST_WAIT_LOCK;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (r_lock_sync) begin
                            r_cnt   <= '0;
                            r_state <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_cnt == c_settle_last) begin
                            r_cnt <= '0;
                            if (r_sweep == 4'(NUM_PHASES)) begin
                                r_state <= ST_ANALYSE;
                            end else begin
                                test_req <= 1'b1;
                                r_state  <= ST_TEST;
                            end
                        end
                    end
                    ST_TEST: begin
                        if (test_ack || (r_cnt == c_timeout_last)) begin
                            pass_map[cur_phase] <= test_ack && test_pass;
                            test_req   <= 1'b0;
                            r_cnt      <= '0;
                            phase_step <= 1'b1;
                            phase_updn <= 1'b1;
                            cur_phase  <= cur_phase + 3'd1;
                            r_sweep    <= r_sweep + 4'd1;
                            r_state    <= ST_STEP_HI;
                        end
                    end
                    ST_STEP_HI, ST_MOVE_HI: begin
                        if (r_cnt == c_step_last) begin
                            r_cnt      <= '0;
                            phase_step <= 1'b0;
                            r_state    <= (r_state == ST_STEP_HI) ? ST_STEP_LO : ST_MOVE_LO;
                        end
                    end
                    ST_STEP_LO: begin
                        if (r_cnt == c_step_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_SETTLE;
                        end
                    end
                    ST_ANALYSE: begin
                        best_phase <= w_best;
                        r_cnt      <= '0;
                        if (!w_accept) begin
                            cal_fail <= 1'b1;
                            r_state  <= ST_FAIL;
                        end else if (w_delta == 3'd0) begin
                            cal_done <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            // Take the shorter way round; a half-turn goes up
                            phase_step <= 1'b1;
                            r_state    <= ST_MOVE_HI;
                            if (w_delta <= 3'd4) begin
                                phase_updn  <= 1'b1;
                                cur_phase   <= cur_phase + 3'd1;
                                r_move_left <= w_delta - 3'd1;
                            end else begin
                                phase_updn  <= 1'b0;
                                cur_phase   <= cur_phase - 3'd1;
                                r_move_left <= (3'd0 - w_delta) - 3'd1;
                            end
                        end
                    end
                    ST_MOVE_LO: begin
                        if (r_cnt == c_step_last) begin
                            r_cnt <= '0;
                            if (r_move_left == 3'd0) begin
                                r_state <= ST_MOVE_SETTLE;
                            end else begin
                                r_move_left <= r_move_left - 3'd1;
                                phase_step  <= 1'b1;
                                cur_phase   <= phase_updn ? cur_phase + 3'd1 : cur_phase - 3'd1;
                                r_state     <= ST_MOVE_HI;
                            end
                        end
                    end
                    ST_MOVE_SETTLE: begin
                        if (r_cnt == c_settle_last) begin
                            cal_done <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/gowin_ddr_read_phase_cal.md
Name: gowin_ddr_read_phase_cal

Overview:
Read-clock phase calibration sequencer that sits directly upstream of the DDR clocking block and drives its phase_step/phase_updn inputs. It sweeps the user-tuned read clock through all 8 PLL phase positions (45° each), querying an external read-pattern checker at each one. It then finds the widest circular passing window and steps the PLL to the window centre. It reports pass map, chosen phase and done/fail status to the PHY sequencer.

Parameters:
NUM_PHASES, 8, phase positions per revolution; fixed by the clocking block's 3-bit phase counter; not to be overridden.
STEP_CYCLES, 4, cycles phase_step is held high, then held low, per step (≥2 each, so the clocking block's edge detect sees every step).
SETTLE_CYCLES, 64, cycles to wait after each step, or after lock, before testing or analysing.
TEST_TIMEOUT, 1024, cycles to wait for test_ack before recording that phase as fail.
MIN_WINDOW, 2, minimum passing run length accepted.

Ports:
clk  in  1  clock shared with the clocking block's phase-control input clock.
rst_n  in  1  asynchronous active-low reset.
locked  in  1  PLL lock from the clocking block; 2-flop synchronised internally.
cal_start  in  1  level; a rising edge in IDLE/DONE/FAIL starts calibration; ignored while busy.
test_req  out  1  request one read-pattern test at the current phase.
test_ack  in  1  one-cycle pulse; test complete.
test_pass  in  1  result; sampled only when test_ack=1.
phase_step  out  1  to the clocking block.
phase_updn  out  1  to the clocking block; 1 = up.
cur_phase  out  3  tracked PLL read phase.
pass_map  out  8  bit i = result at phase i.
best_phase  out  3  selected centre phase.
cal_busy  out  1  high in every state except IDLE/DONE/FAIL.
cal_done  out  1  high in DONE.
cal_fail  out  1  high in FAIL.

Behaviour:
- Reset: all outputs 0, FSM=IDLE. cur_phase=0 matches the clocking block's reset phase. Both blocks must share reset.
- States: IDLE, WAIT_LOCK, SETTLE, TEST, STEP_HI, STEP_LO, ANALYSE, MOVE_HI, MOVE_LO, MOVE_SETTLE, DONE, FAIL.
- Start: clear pass_map, set sweep count=0, go to WAIT_LOCK. WAIT_LOCK goes to SETTLE once sync'd locked=1. SETTLE counts SETTLE_CYCLES, then goes to TEST.
- TEST: test_req=1 until the test_ack cycle. pass_map[cur_phase]<=test_pass. test_req=0 from the next cycle. If TEST_TIMEOUT expires with no ack, record 0 and drop test_req. An ack arriving in the same cycle as timeout takes precedence.
- Sweep step: STEP_HI asserts phase_updn=1 and phase_step=1 for STEP_CYCLES, and cur_phase<=cur_phase+1 (3-bit wrap, 7→0) on entry. STEP_LO sets phase_step=0 for STEP_CYCLES with phase_updn held stable. Then SETTLE. After 8 tests and 8 steps, cur_phase equals the start phase, and the FSM goes to ANALYSE instead of TEST.
- ANALYSE (1 cycle, registered): find the longest circular run of 1s in pass_map.
  - Run start = index i with bit i=1 and bit (i-1) mod 8 = 0. Tie → lowest start index.
  - best_phase = (start + (len-1)/2) mod 8, floor.
  - All 8 pass → best_phase=0, len=8.
  - len < MIN_WINDOW (including all-fail) → FAIL.
- MOVE: delta=(best_phase-cur_phase) mod 8.
  - delta=0 → DONE.
  - delta≤4 → step up delta times; else step down 8-delta times (phase_updn=0, cur_phase decrements).
  - Each step is MOVE_HI/MOVE_LO with the same timing as the sweep. After the final step, MOVE_SETTLE (SETTLE_CYCLES), then DONE.
- DONE/FAIL: hold status, pass_map, best_phase. A new cal_start edge clears cal_done/cal_fail and restarts from the current phase.
- Lock loss: sync'd locked=0 in any busy state after WAIT_LOCK → FAIL next cycle, phase_step=0, test_req=0, cur_phase retained.
- phase_step is never high in two consecutive steps without ≥STEP_CYCLES low between them.

Decomposition:
- Package gowin_ddr_pkg: cal_state_t enum, NUM_PHASES, PHASE_W=3 constant.
- Sub-module gowin_ddr_phase_window_find: combinational; pass_map[7:0] and MIN_WINDOW in; best_phase, win_len[3:0], win_ok out. Verified standalone, exhaustively over 256 maps.

Test Plan:
- Checker passes phases 2..5 only, locked=1 → pass_map=8'h3C; best_phase=3; 3 up-steps after the sweep; cal_done=1; cur_phase=3.
- Map 8'b1000_0011 (phases 7,0,1 pass) → best_phase=0 (wrap window start 7, len 3); zero move steps; cal_done.
- Map 8'h00 → cal_fail=1 after the sweep; no move steps; cur_phase=0. Map 8'hFF → best_phase=0, done.
- Map 8'h70 (best 5) starting from cur_phase=0 → delta=5, 3 down-steps with phase_updn=0; each phase_step high exactly 4 cycles then low 4.
- test_ack withheld at phase 4 → test_req drops after 1024 cycles; bit 4=0; sweep continues.
- locked deasserted in the settle after the 3rd step → cal_fail next cycle, test_req=0, phase_step=0; rst_n low mid-sweep → all outputs 0 immediately.
